// File: rtl/bpm_test_link_reader.sv
// ============================================================================
// Module   : bpm_test_link_reader
// Purpose  : BPM test-link RX parser. It checks framing and magic, extracts the
//            index and payload, reports a status per packet and counts good,
//            error and missed packets.
// Option   : BPM_TEST_LINK_READER_SEQ_CHECK_EN adds seqErrorCount.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpm_test_link_reader #(
    parameter int          MAGIC_WIDTH     = 16,
    parameter int          MAGIC_START_BIT = 16,
    parameter int          INDEX_WIDTH     = 5,
    parameter int          INDEX_START_BIT = 10,
    parameter int          NUM_DATA_WORDS  = 3,
    parameter logic [15:0] EXPECTED_MAGIC  = 16'hA5BE
) (
    input  logic                         auroraUserClk,
    input  logic                         auroraReset,
    input  logic                         auroraChannelUp,
    input  logic                         auroraFAstrobe,
    input  logic [31:0]                  BPM_TEST_AXI_STREAM_RX_tdata,
    input  logic                         BPM_TEST_AXI_STREAM_RX_tvalid,
    input  logic                         BPM_TEST_AXI_STREAM_RX_tlast,
`ifdef BPM_TEST_LINK_READER_SEQ_CHECK_EN
    output logic [15:0]                  seqErrorCount,
`endif
    output logic                         statusStrobe,
    output logic [1:0]                   statusCode,
    output logic                         packetStrobe,
    output logic [INDEX_WIDTH-1:0]       packetIndex,
    output logic [32*NUM_DATA_WORDS-1:0] packetData,
    output logic [15:0]                  goodCount,
    output logic [15:0]                  errorCount,
    output logic [15:0]                  missedCount
);

    localparam int DATA_W = 32 * NUM_DATA_WORDS;
    localparam int CNT_W  = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
    localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(NUM_DATA_WORDS - 1);

    localparam logic [1:0] c_OK        = 2'd0;
    localparam logic [1:0] c_BAD_MAGIC = 2'd1;
    localparam logic [1:0] c_SHORT     = 2'd2;
    localparam logic [1:0] c_LONG      = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_wordCnt;
    logic [INDEX_WIDTH-1:0]   r_shadowIndex;
    logic [DATA_W-1:0]        r_shadowData;
    logic                     r_statusStrobe;
    logic [1:0]               r_statusCode;
    logic                     r_packetStrobe;
    logic [INDEX_WIDTH-1:0]   r_packetIndex;
    logic [DATA_W-1:0]        r_packetData;
    logic [15:0]              r_goodCount;
    logic [15:0]              r_errorCount;
    logic [15:0]              r_missedCount;
    logic                     r_armed;
    logic                     r_okSeen;

    logic                     w_beat;
    logic [MAGIC_WIDTH-1:0]   w_magic;
    logic                     w_report;
    logic [1:0]               w_code;
    logic                     w_ok;
    state_t                   w_nextState;
    logic [DATA_W-1:0]        w_fullData;

    assign w_beat  = BPM_TEST_AXI_STREAM_RX_tvalid && auroraChannelUp;
    assign w_magic = BPM_TEST_AXI_STREAM_RX_tdata[MAGIC_START_BIT +: MAGIC_WIDTH];
    assign w_ok    = w_report && (w_code == c_OK);

    always_comb begin
        w_report    = 1'b0;
        w_code      = c_OK;
        w_nextState = r_state;
        if (w_beat) begin
            case (r_state)
                S_IDLE: begin
                    if (w_magic != EXPECTED_MAGIC[MAGIC_WIDTH-1:0]) begin
                        w_report    = 1'b1;
                        w_code      = c_BAD_MAGIC;
                        w_nextState = BPM_TEST_AXI_STREAM_RX_tlast ? S_IDLE : S_DRAIN;
                    end else if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        w_report = 1'b1;
                        w_code   = c_SHORT;
                    end else begin
                        w_nextState = S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_wordCnt == c_LAST_WORD) begin
                        w_report    = 1'b1;
                        w_code      = BPM_TEST_AXI_STREAM_RX_tlast ? c_OK : c_LONG;
                        w_nextState = BPM_TEST_AXI_STREAM_RX_tlast ? S_IDLE : S_DRAIN;
                    end else if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        w_report    = 1'b1;
                        w_code      = c_SHORT;
                        w_nextState = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        w_nextState = S_IDLE;
                    end
                end
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // The final data word is published straight from the bus, not from the shadow.
    always_comb begin
        w_fullData = r_shadowData;
        w_fullData[DATA_W-32 +: 32] = BPM_TEST_AXI_STREAM_RX_tdata;
    end

    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            r_state        <= S_IDLE;
            r_wordCnt      <= '0;
            r_shadowIndex  <= '0;
            r_shadowData   <= '0;
            r_statusStrobe <= 1'b0;
            r_statusCode   <= c_OK;
            r_packetStrobe <= 1'b0;
            r_packetIndex  <= '0;
            r_packetData   <= '0;
            r_goodCount    <= '0;
            r_errorCount   <= '0;
            r_missedCount  <= '0;
            r_armed        <= 1'b0;
            r_okSeen       <= 1'b0;
        end else begin
            r_statusStrobe <= w_report;
            r_statusCode   <= w_code;
            r_packetStrobe <= w_ok;
            if (!auroraChannelUp) begin
                r_state   <= S_IDLE;
                r_wordCnt <= '0;
                r_armed   <= 1'b0;
                r_okSeen  <= 1'b0;
            end else begin
                r_state <= w_nextState;
                if (w_beat && r_state == S_IDLE) begin
                    r_shadowIndex <= BPM_TEST_AXI_STREAM_RX_tdata[INDEX_START_BIT +: INDEX_WIDTH];
                    r_wordCnt     <= '0;
                end else if (w_beat && r_state == S_DATA) begin
                    r_shadowData[r_wordCnt*32 +: 32] <= BPM_TEST_AXI_STREAM_RX_tdata;
                    r_wordCnt <= r_wordCnt + 1'b1;
                end
                if (w_ok) begin
                    r_packetIndex <= r_shadowIndex;
                    r_packetData  <= w_fullData;
                    if (r_goodCount != 16'hFFFF) r_goodCount <= r_goodCount + 16'd1;
                end
                if (w_report && !w_ok && r_errorCount != 16'hFFFF) begin
                    r_errorCount <= r_errorCount + 16'd1;
                end
                // An OK decided in the strobe cycle belongs to the interval being closed.
                if (auroraFAstrobe) begin
                    r_armed  <= 1'b1;
                    r_okSeen <= 1'b0;
                    if (r_armed && !r_okSeen && !w_ok && r_missedCount != 16'hFFFF) begin
                        r_missedCount <= r_missedCount + 16'd1;
                    end
                end else if (w_ok) begin
                    r_okSeen <= 1'b1;
                end
            end
        end
    end

`ifdef BPM_TEST_LINK_READER_SEQ_CHECK_EN
    logic [15:0]            r_seqErrorCount;
    logic [INDEX_WIDTH-1:0] r_prevIndex;
    logic                   r_haveGood;

    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            r_seqErrorCount <= '0;
            r_prevIndex     <= '0;
            r_haveGood      <= 1'b0;
        end else if (!auroraChannelUp) begin
            r_haveGood <= 1'b0;
        end else if (w_ok) begin
            r_prevIndex <= r_shadowIndex;
            r_haveGood  <= 1'b1;
            if (r_haveGood && r_shadowIndex != r_prevIndex + 1'b1 &&
                r_seqErrorCount != 16'hFFFF) begin
                r_seqErrorCount <= r_seqErrorCount + 16'd1;
            end
        end
    end

    assign seqErrorCount = r_seqErrorCount;
`endif

    assign statusStrobe = r_statusStrobe;
    assign statusCode   = r_statusCode;
    assign packetStrobe = r_packetStrobe;
    assign packetIndex  = r_packetIndex;
    assign packetData   = r_packetData;
    assign goodCount    = r_goodCount;
    assign errorCount   = r_errorCount;
    assign missedCount  = r_missedCount;

endmodule

`default_nettype wire
